// File: rtl/first_counter_pkg.sv
// ============================================================================
// Module   : first_counter_pkg
// Brief    : Shared widths and monitor state encoding for the first counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package first_counter_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2,
        HOLDOFF = 2'd3
    } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/first_counter_wrap_detect.sv
// ============================================================================
// Module   : first_counter_wrap_detect
// Brief    : Registers the previous counter/overflow values and flags 15->0
//            wraps and upstream resets. FIRST_COUNTER_MATCH_EN adds a match edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module first_counter_wrap_detect (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [first_counter_pkg::COUNT_W-1:0] counter_in,
    input  logic                                 overflow_in,
`ifdef FIRST_COUNTER_MATCH_EN
    input  logic [first_counter_pkg::COUNT_W-1:0] match_value,
    output logic                                 match_edge,
`endif
    output logic                                 wrap,
    output logic                                 up_reset
);
    import first_counter_pkg::*;

    logic [COUNT_W-1:0] r_prev;
    logic               r_prev_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_prev_ovf <= 1'b0;
        end else begin
            r_prev     <= counter_in;
            r_prev_ovf <= overflow_in;
        end
    end

    assign wrap     = (r_prev == COUNT_MAX) && (counter_in == '0);
    // A falling sticky flag can only mean the upstream counter was reset.
    assign up_reset = r_prev_ovf && !overflow_in;

`ifdef FIRST_COUNTER_MATCH_EN
    assign match_edge = (counter_in == match_value) && (r_prev != match_value);
`endif

endmodule

`default_nettype wire

// File: rtl/first_counter_monitor.sv
// ============================================================================
// Module   : first_counter_monitor
// Brief    : Counts counter wraps and raises an acked level IRQ every
//            IRQ_EVERY wraps. FIRST_COUNTER_MATCH_EN adds match_value/match_out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module first_counter_monitor #(
    parameter int WRAP_W    = 8,
    parameter int IRQ_EVERY = 1,
    parameter int HOLDOFF   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [first_counter_pkg::COUNT_W-1:0] counter_in,
    input  logic                                 overflow_in,
    input  logic                                 irq_ack,
`ifdef FIRST_COUNTER_MATCH_EN
    input  logic [first_counter_pkg::COUNT_W-1:0] match_value,
    output logic                                 match_out,
`endif
    output logic                                 irq_out,
    output logic [WRAP_W-1:0]                    wrap_count_out,
    output logic                                 missed_out,
    output logic [1:0]                           state_out
);
    import first_counter_pkg::*;

    localparam logic [1:0]        S_IDLE      = first_counter_pkg::IDLE;
    localparam logic [1:0]        S_ARMED     = first_counter_pkg::ARMED;
    localparam logic [1:0]        S_PENDING   = first_counter_pkg::PENDING;
    localparam logic [1:0]        S_HOLDOFF   = first_counter_pkg::HOLDOFF;
    localparam logic [WRAP_W-1:0] C_IRQ_EVERY = WRAP_W'(IRQ_EVERY);
    localparam logic [WRAP_W-1:0] C_WRAP_MAX  = '1;
    localparam logic [3:0]        C_HOLD_LOAD = 4'(HOLDOFF - 1);

    logic              w_wrap;
    logic              w_up_reset;
    logic [WRAP_W-1:0] w_since_next;
    logic [WRAP_W-1:0] w_count_inc;
    logic              w_hit;

    logic [1:0]        r_state;
    logic              r_irq;
    logic [WRAP_W-1:0] r_wrap_count;
    logic [WRAP_W-1:0] r_since;
    logic              r_missed;
    logic [3:0]        r_hold;

`ifdef FIRST_COUNTER_MATCH_EN
    logic w_match_edge;
    logic r_match;
`endif

    first_counter_wrap_detect u_detect (
        .clk         (clk),
        .reset       (reset),
        .counter_in  (counter_in),
        .overflow_in (overflow_in),
`ifdef FIRST_COUNTER_MATCH_EN
        .match_value (match_value),
        .match_edge  (w_match_edge),
`endif
        .wrap        (w_wrap),
        .up_reset    (w_up_reset)
    );

    assign w_since_next = r_since + WRAP_W'(1);
    assign w_count_inc  = (r_wrap_count == C_WRAP_MAX) ? r_wrap_count
                                                       : r_wrap_count + WRAP_W'(1);
    assign w_hit        = w_wrap && (w_since_next == C_IRQ_EVERY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_irq        <= 1'b0;
            r_wrap_count <= '0;
            r_since      <= '0;
            r_missed     <= 1'b0;
            r_hold       <= 4'd0;
        end else if (w_up_reset) begin
            r_state      <= S_IDLE;
            r_irq        <= 1'b0;
            r_wrap_count <= '0;
            r_since      <= '0;
            r_hold       <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (overflow_in) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_wrap) begin
                        r_wrap_count <= w_count_inc;
                        if (w_hit) begin
                            r_since <= '0;
                            r_irq   <= 1'b1;
                            r_state <= S_PENDING;
                        end else begin
                            r_since <= w_since_next;
                        end
                    end
                end
                S_PENDING, S_HOLDOFF: begin
                    // An interval completed while the previous IRQ is still outstanding.
                    if (w_wrap) begin
                        r_wrap_count <= w_count_inc;
                        if (w_hit) begin
                            r_since  <= '0;
                            r_missed <= 1'b1;
                        end else begin
                            r_since  <= w_since_next;
                        end
                    end
                    if (r_state == S_PENDING) begin
                        if (irq_ack) begin
                            r_irq <= 1'b0;
                            if (HOLDOFF == 0) begin
                                r_state <= S_ARMED;
                            end else begin
                                r_state <= S_HOLDOFF;
                                r_hold  <= C_HOLD_LOAD;
                            end
                        end
                    end else if (r_hold == 4'd0) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_hold <= r_hold - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIRST_COUNTER_MATCH_EN
    always_ff @(posedge clk) begin
        if (reset) r_match <= 1'b0;
        else       r_match <= w_match_edge && (r_state != S_IDLE);
    end
    assign match_out = r_match;
`endif

    assign irq_out        = r_irq;
    assign wrap_count_out = r_wrap_count;
    assign missed_out     = r_missed;
    assign state_out      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_first_counter_monitor.sv
// ============================================================================
// Module   : tb_first_counter_monitor
// Brief    : Directed bench for first_counter_monitor (two parameter sets);
//            match checks are built when FIRST_COUNTER_MATCH_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_first_counter_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] counter_in = 4'h0;
    logic       overflow_in = 1'b0;
    logic       irq_ack = 1'b0;

    logic       a_irq, b_irq, a_missed, b_missed;
    logic [7:0] a_wc;
    logic [1:0] b_wc;
    logic [1:0] a_st, b_st;

`ifdef FIRST_COUNTER_MATCH_EN
    logic [3:0] match_value = 4'h7;
    logic       a_match, b_match;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    first_counter_monitor #(.WRAP_W(8), .IRQ_EVERY(2), .HOLDOFF(2)) dut_a (
        .clk(clk), .reset(reset), .counter_in(counter_in), .overflow_in(overflow_in),
        .irq_ack(irq_ack),
`ifdef FIRST_COUNTER_MATCH_EN
        .match_value(match_value), .match_out(a_match),
`endif
        .irq_out(a_irq), .wrap_count_out(a_wc), .missed_out(a_missed), .state_out(a_st)
    );

    first_counter_monitor #(.WRAP_W(2), .IRQ_EVERY(1), .HOLDOFF(0)) dut_b (
        .clk(clk), .reset(reset), .counter_in(counter_in), .overflow_in(overflow_in),
        .irq_ack(irq_ack),
`ifdef FIRST_COUNTER_MATCH_EN
        .match_value(match_value), .match_out(b_match),
`endif
        .irq_out(b_irq), .wrap_count_out(b_wc), .missed_out(b_missed), .state_out(b_st)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
        logic       ack;
        logic       irq;
        logic [7:0] wc;
        logic       missed;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic o, input logic a);
        counter_in  = c;
        overflow_in = o;
        irq_ack     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step(4'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic wrap_b();
        step(4'hF, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        // {cnt, ovf, ack} -> {irq, wrap_count, missed, state} for dut_a
        vecs[0]  = {4'hF, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0};
        vecs[1]  = {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1};
        vecs[2]  = {4'hF, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1};
        vecs[3]  = {4'h0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 2'd1};
        vecs[4]  = {4'hF, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 2'd1};
        vecs[5]  = {4'h0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 2'd2};
        vecs[6]  = {4'hF, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 2'd2};
        vecs[7]  = {4'h0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 2'd2};
        vecs[8]  = {4'h1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 2'd3};
        vecs[9]  = {4'h2, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 2'd3};
        vecs[10] = {4'h3, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 2'd1};
        vecs[11] = {4'h4, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 2'd1};
        vecs[12] = {4'hF, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 2'd1};
        vecs[13] = {4'h0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 2'd2};
        vecs[14] = {4'hF, 1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 2'd3};
        vecs[15] = {4'h0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 2'd3};
        vecs[16] = {4'hF, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 2'd1};
        vecs[17] = {4'h0, 1'b1, 1'b0, 1'b1, 8'd6, 1'b0, 2'd2};
        vecs[18] = {4'hF, 1'b1, 1'b0, 1'b1, 8'd6, 1'b0, 2'd2};
        vecs[19] = {4'h0, 1'b1, 1'b1, 1'b0, 8'd7, 1'b0, 2'd3};
        vecs[20] = {4'hF, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 2'd3};
        vecs[21] = {4'h0, 1'b1, 1'b0, 1'b0, 8'd8, 1'b1, 2'd1};
        vecs[22] = {4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 2'd0};
        vecs[23] = {4'h6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 2'd0};

        do_reset();
        chk("reset_a", {a_irq, a_wc, a_missed, a_st}, 32'h0);
        chk("reset_b", {b_irq, b_wc, b_missed, b_st}, 32'h0);

        // Free-running counter without overflow: wraps are ignored in IDLE.
        for (int i = 1; i < 22; i++) begin
            step(4'(i % 16), 1'b0, 1'b0);
            chk($sformatf("idle_run_%0d", i), {a_irq, a_wc, a_missed, a_st}, 32'h0);
        end

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].cnt, vecs[i].ovf, vecs[i].ack);
            chk($sformatf("vec%0d", i), {a_irq, a_wc, a_missed, a_st},
                {20'h0, vecs[i].irq, vecs[i].wc, vecs[i].missed, vecs[i].st});
        end

        // Missed interrupt, saturation and upstream reset on the narrow instance.
        do_reset();
        step(4'h0, 1'b1, 1'b0);
        chk("b_armed", b_st, 32'd1);
        wrap_b();
        chk("b_wrap1", {b_irq, b_wc, b_missed, b_st}, {27'h0, 1'b1, 2'd1, 1'b0, 2'd2});
        wrap_b();
        chk("b_missed", b_missed, 32'd1);
        wrap_b();
        chk("b_wrap3", {b_irq, b_wc, b_missed, b_st}, {27'h0, 1'b1, 2'd3, 1'b1, 2'd2});
        step(4'h5, 1'b1, 1'b1);
        chk("b_ack", {b_irq, b_missed, b_st}, {28'h0, 1'b0, 1'b1, 2'd1});
        wrap_b();
        chk("b_rearm_irq", b_irq, 32'd1);
        wrap_b();
        chk("b_saturate", b_wc, 32'd3);
        chk("a_nosat", a_wc, 32'd5);
        chk("a_missed_holdoff", a_missed, 32'd1);
        step(4'h1, 1'b0, 1'b0);
        chk("b_upreset", {b_irq, b_wc, b_missed, b_st}, {27'h0, 1'b0, 2'd0, 1'b1, 2'd0});

        // Reset while an interrupt is pending drops everything.
        step(4'h2, 1'b1, 1'b0);
        wrap_b();
        chk("b_pend_before_rst", {b_irq, b_st}, {29'h0, 1'b1, 2'd2});
        reset = 1'b1;
        step(4'h3, 1'b1, 1'b0);
        reset = 1'b0;
        chk("b_midreset", {b_irq, b_wc, b_missed, b_st}, 32'h0);
        chk("a_midreset", {a_irq, a_wc, a_missed, a_st}, 32'h0);

`ifdef FIRST_COUNTER_MATCH_EN
        begin
            logic [3:0] tb_prev;
            logic [3:0] seq [14];
            do_reset();
            for (int i = 1; i < 23; i++) begin
                step(4'(i % 16), 1'b0, 1'b0);
                chk($sformatf("match_idle_%0d", i), a_match, 32'd0);
            end
            step(4'h6, 1'b1, 1'b0);
            tb_prev = 4'h6;
            seq = '{4'h7, 4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'h3,
                    4'h6, 4'h7, 4'h8, 4'h7, 4'h7, 4'h2};
            for (int i = 0; i < 14; i++) begin
                step(seq[i], 1'b1, 1'b0);
                chk($sformatf("match_%0d", i), a_match,
                    {31'h0, (seq[i] == 4'h7) && (tb_prev != 4'h7)});
                tb_prev = seq[i];
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
